// File: rtl/bus_master_6502.sv
// 6502 bus initiator: runs queued read/write commands as phi1/phi2 bus cycles
// and returns read data through a single-entry response slot.
module bus_master_6502 #(
  parameter int unsigned PHI1_TICKS = 4,
  parameter int unsigned PHI2_TICKS = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [15:0] ab,
  output logic        rw,
  output logic [7:0]  db_o,
  input  logic [7:0]  db_i,
  output logic        clk2out,
  output logic        busy
);

  localparam int unsigned MAX_TICKS = (PHI1_TICKS > PHI2_TICKS) ? PHI1_TICKS : PHI2_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  PHI1_LAST = CNT_W'(PHI1_TICKS - 1);
  localparam logic [CNT_W-1:0]  PHI2_LAST = CNT_W'(PHI2_TICKS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic {
    PHI1 = 1'b0,
    PHI2 = 1'b1
  } phase_e;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  phase_e            state_q, state_d;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic              clk2out_q, clk2out_d;

  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;

  logic [15:0]       ab_q, ab_d;
  logic              rw_q, rw_d;
  logic [7:0]        db_o_q, db_o_d;
  logic              active_q, active_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;

  cmd_t              head_c;
  cmd_t              push_cmd_c;
  logic              launch_slot_c;
  logic              phi2_end_c;
  logic              full_c;
  logic              pop_c;
  logic              push_c;
  logic              capture_c;
  logic              cmd_ready_c;

  // Launch/capture timing and FIFO handshake flags
  assign launch_slot_c = (state_q == PHI1) && (tick_q == '0);
  assign phi2_end_c    = (state_q == PHI2) && (tick_q == PHI2_LAST);
  assign head_c        = mem_q[rd_ptr_q];
  assign full_c        = (count_q == FIFO_FULL);
  assign pop_c         = launch_slot_c && (count_q != '0) && (!head_c.rd || !rsp_valid_q);
  assign cmd_ready_c   = !full_c || pop_c;
  assign push_c        = cmd_valid && cmd_ready_c;
  assign capture_c     = phi2_end_c && active_q && rw_q;
  assign push_cmd_c    = '{rd: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

  // Phase sequencer: PHI1 -> PHI2 -> PHI1, counter cleared on each phase change
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + CNT_W'(1);
    if (state_q == PHI1) begin
      if (tick_q == PHI1_LAST) begin
        state_d = PHI2;
        tick_d  = '0;
      end
    end else begin
      if (tick_q == PHI2_LAST) begin
        state_d = PHI1;
        tick_d  = '0;
      end
    end
    clk2out_d = (state_d == PHI2);
  end

  // Command FIFO: simultaneous push and pop keep the count unchanged
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = push_cmd_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - FCNT_W'(1);
    end
  end

  // Bus drive, read capture, response slot and busy tracking
  always_comb begin
    ab_d        = ab_q;
    rw_d        = rw_q;
    db_o_d      = db_o_q;
    active_d    = active_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (launch_slot_c) begin
      if (pop_c) begin
        ab_d     = head_c.addr;
        rw_d     = head_c.rd;
        active_d = 1'b1;
        if (!head_c.rd) begin
          db_o_d = head_c.wdata;
        end
      end else begin
        rw_d = 1'b1;
      end
    end
    if (phi2_end_c) begin
      active_d = 1'b0;
    end
    if (capture_c) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = db_i;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    busy_d = (count_d != '0) || active_d;
  end

  // State registers; reset aborts any cycle in flight
  always_ff @(posedge eclk or negedge ereset) begin
    if (!ereset) begin
      state_q     <= PHI1;
      tick_q      <= '0;
      clk2out_q   <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ab_q        <= '0;
      rw_q        <= 1'b1;
      db_o_q      <= '0;
      active_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      clk2out_q   <= clk2out_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ab_q        <= ab_d;
      rw_q        <= rw_d;
      db_o_q      <= db_o_d;
      active_q    <= active_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ab        = ab_q;
  assign rw        = rw_q;
  assign db_o      = db_o_q;
  assign clk2out   = clk2out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_master_6502.sv
// Bench for bus_master_6502: a 4/4 instance for the main scenarios and a
// 1/1 instance for the single-tick phase boundary.
module tb_bus_master_6502;

  logic eclk = 1'b0;
  always #5 eclk = ~eclk;

  // 4/4 instance signals
  logic        ereset_a, cmd_valid_a, cmd_ready_a, cmd_rw_a;
  logic [15:0] cmd_addr_a, ab_a;
  logic [7:0]  cmd_wdata_a, rsp_data_a, db_o_a, db_i_a;
  logic        rsp_valid_a, rsp_ready_a, rw_a, clk2out_a, busy_a;

  // 1/1 instance signals
  logic        ereset_b, cmd_valid_b, cmd_ready_b, cmd_rw_b;
  logic [15:0] cmd_addr_b, ab_b;
  logic [7:0]  cmd_wdata_b, rsp_data_b, db_o_b, db_i_b;
  logic        rsp_valid_b, rsp_ready_b, rw_b, clk2out_b, busy_b;

  logic [7:0] mem_a [65536];
  logic [7:0] mem_b [65536];

  int n_tests = 0;
  int n_fail  = 0;

  bus_master_6502 #(.PHI1_TICKS(4), .PHI2_TICKS(4), .FIFO_DEPTH(4)) u_dut_a (
    .eclk(eclk), .ereset(ereset_a),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_rw(cmd_rw_a),
    .cmd_addr(cmd_addr_a), .cmd_wdata(cmd_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
    .ab(ab_a), .rw(rw_a), .db_o(db_o_a), .db_i(db_i_a),
    .clk2out(clk2out_a), .busy(busy_a)
  );

  bus_master_6502 #(.PHI1_TICKS(1), .PHI2_TICKS(1), .FIFO_DEPTH(4)) u_dut_b (
    .eclk(eclk), .ereset(ereset_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_rw(cmd_rw_b),
    .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
    .ab(ab_b), .rw(rw_b), .db_o(db_o_b), .db_i(db_i_b),
    .clk2out(clk2out_b), .busy(busy_b)
  );

  // Simple RAM models: write on the phi2 edge, combinational read
  always @(posedge eclk) begin
    if (!ereset_a) begin
      mem_a[16'h0000] <= 8'h11;
      mem_a[16'h0001] <= 8'h22;
      mem_a[16'h0002] <= 8'h33;
      mem_a[16'h1234] <= 8'h5C;
    end else if (clk2out_a && !rw_a) begin
      mem_a[ab_a] <= db_o_a;
    end
  end

  always @(posedge eclk) begin
    if (!ereset_b) begin
      mem_b[16'hFFFF] <= 8'h00;
    end else if (clk2out_b && !rw_b) begin
      mem_b[ab_b] <= db_o_b;
    end
  end

  assign db_i_a = mem_a[ab_a];
  assign db_i_b = mem_b[ab_b];

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  task automatic tick();
    @(posedge eclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_a();
    cmd_valid_a = 1'b0;
    rsp_ready_a = 1'b0;
    ereset_a    = 1'b0;
    repeat (3) tick();
    ereset_a = 1'b1;
  endtask

  task automatic push_a(input logic rd, input logic [15:0] addr, input logic [7:0] wd);
    logic ok;
    ok          = 1'b0;
    cmd_valid_a = 1'b1;
    cmd_rw_a    = rd;
    cmd_addr_a  = addr;
    cmd_wdata_a = wd;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = cmd_ready_a;
      tick();
    end
    cmd_valid_a = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle_a(input string name);
    for (int i = 0; i < 100 && busy_a; i++) tick();
    chk(name, 32'(busy_a), 32'd0);
  endtask

  task automatic wait_rsp_a(input string name);
    for (int i = 0; i < 100 && !rsp_valid_a; i++) tick();
    chk(name, 32'(rsp_valid_a), 32'd1);
  endtask

  task automatic consume_a();
    rsp_ready_a = 1'b1;
    tick();
    rsp_ready_a = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid_a), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [8];
    logic [23:0] seen24, exp24;
    logic [15:0] seen16, exp16;
    logic [11:0] seen12, exp12;
    int          viol, ready_lo;
    logic [7:0]  rq [$];

    vecs[0] = '{1'b0, 16'h0010, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 16'h0010, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 16'h0011, 8'hC3, 8'h00};
    vecs[3] = '{1'b0, 16'h0010, 8'h5A, 8'h00};
    vecs[4] = '{1'b1, 16'h0011, 8'h00, 8'hC3};
    vecs[5] = '{1'b1, 16'h0010, 8'h00, 8'h5A};
    vecs[6] = '{1'b0, 16'hFFFF, 8'h01, 8'h00};
    vecs[7] = '{1'b1, 16'hFFFF, 8'h00, 8'h01};

    ereset_a = 1'b0; ereset_b = 1'b0;
    cmd_valid_a = 1'b0; cmd_rw_a = 1'b1; cmd_addr_a = '0; cmd_wdata_a = '0; rsp_ready_a = 1'b0;
    cmd_valid_b = 1'b0; cmd_rw_b = 1'b1; cmd_addr_b = '0; cmd_wdata_b = '0; rsp_ready_b = 1'b1;

    // Reset state
    reset_a();
    chk("rst_ab", 32'(ab_a), 32'h0);
    chk("rst_rw", 32'(rw_a), 32'h1);
    chk("rst_db_o", 32'(db_o_a), 32'h0);
    chk("rst_clk2out", 32'(clk2out_a), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_a), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready_a), 32'h1);

    // Write 0x0200<-0xA5 then read it back, cycle-exact
    seen24 = '0; exp24 = '0;
    for (int k = 0; k < 25; k++) begin
      if (k < 24) begin
        seen24[k] = clk2out_a;
        exp24[k]  = ((k % 8) >= 4);
      end
      cmd_valid_a = (k < 2);
      cmd_rw_a    = (k == 1);
      cmd_addr_a  = 16'h0200;
      cmd_wdata_a = 8'hA5;
      if (k == 1) chk("wr_busy_after_push", 32'(busy_a), 32'h1);
      if (k == 12) begin
        chk("wr_rw", 32'(rw_a), 32'h0);
        chk("wr_ab", 32'(ab_a), 32'h0200);
        chk("wr_db_o", 32'(db_o_a), 32'hA5);
      end
      if (k == 20) begin
        chk("rd_rw", 32'(rw_a), 32'h1);
        chk("rd_db_o_held", 32'(db_o_a), 32'hA5);
      end
      if (k == 23) chk("rd_rsp_not_yet", 32'(rsp_valid_a), 32'h0);
      if (k == 24) begin
        chk("rd_rsp_valid", 32'(rsp_valid_a), 32'h1);
        chk("rd_rsp_data", 32'(rsp_data_a), 32'hA5);
        chk("rd_busy_done", 32'(busy_a), 32'h0);
      end
      if (k < 24) tick();
    end
    chk("clk2out_period8", 32'(seen24), 32'(exp24));
    consume_a();

    // Table of write/read commands, each run to completion
    for (int i = 0; i < 8; i++) begin
      push_a(vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      wait_idle_a("vec_idle");
      chk("vec_ab", 32'(ab_a), 32'(vecs[i].addr));
      chk("vec_rw", 32'(rw_a), 32'(vecs[i].rd));
      if (vecs[i].rd) begin
        chk("vec_rsp_valid", 32'(rsp_valid_a), 32'h1);
        chk("vec_rsp_data", 32'(rsp_data_a), 32'(vecs[i].exp_rdata));
        consume_a();
      end else begin
        chk("vec_db_o", 32'(db_o_a), 32'(vecs[i].wdata));
      end
    end

    // Response backpressure: blocked read holds the head
    reset_a();
    cmd_valid_a = 1'b1;
    cmd_rw_a    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_addr_a = 16'(k);
      chk("bp_push_ready", 32'(cmd_ready_a), 32'h1);
      tick();
    end
    cmd_valid_a = 1'b0;
    viol = 0; ready_lo = 0;
    for (int k = 3; k < 40; k++) begin
      if (k >= 16 && (!rw_a || ab_a != 16'h0000)) viol++;
      if (!cmd_ready_a) ready_lo++;
      tick();
    end
    chk("bp_idle_cycles", 32'(viol), 32'h0);
    chk("bp_cmd_ready_high", 32'(ready_lo), 32'h0);
    chk("bp_rsp_valid", 32'(rsp_valid_a), 32'h1);
    chk("bp_rsp0", 32'(rsp_data_a), 32'h11);
    chk("bp_busy", 32'(busy_a), 32'h1);
    consume_a();
    wait_rsp_a("bp_rsp1_valid");
    chk("bp_rsp1", 32'(rsp_data_a), 32'h22);
    chk("bp_ab1", 32'(ab_a), 32'h0001);
    consume_a();
    wait_rsp_a("bp_rsp2_valid");
    chk("bp_rsp2", 32'(rsp_data_a), 32'h33);
    chk("bp_ab2", 32'(ab_a), 32'h0002);
    consume_a();
    wait_idle_a("bp_idle");

    // FIFO full: four pushes fill it, fifth waits for the first pop
    reset_a();
    cmd_valid_a = 1'b1;
    cmd_rw_a    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmd_addr_a  = 16'h0300 + 16'(k);
      cmd_wdata_a = 8'(k + 1);
      tick();
    end
    cmd_addr_a  = 16'h0304;
    cmd_wdata_a = 8'h05;
    chk("full_ready_lo_c4", 32'(cmd_ready_a), 32'h0);
    repeat (3) tick();
    chk("full_ready_lo_c7", 32'(cmd_ready_a), 32'h0);
    tick();
    chk("full_push_pop_ready", 32'(cmd_ready_a), 32'h1);
    tick();
    cmd_valid_a = 1'b0;
    chk("full_again", 32'(cmd_ready_a), 32'h0);
    chk("full_first_ab", 32'(ab_a), 32'h0300);
    chk("full_first_rw", 32'(rw_a), 32'h0);
    chk("full_first_db_o", 32'(db_o_a), 32'h01);
    wait_idle_a("full_idle");
    chk("full_last_ab", 32'(ab_a), 32'h0304);
    chk("full_last_db_o", 32'(db_o_a), 32'h05);
    chk("full_mem_0302", 32'(mem_a[16'h0302]), 32'h03);

    // Reset during phi2 of a write
    reset_a();
    push_a(1'b0, 16'h0400, 8'h77);
    repeat (11) tick();
    chk("mid_clk2out", 32'(clk2out_a), 32'h1);
    chk("mid_rw", 32'(rw_a), 32'h0);
    chk("mid_ab", 32'(ab_a), 32'h0400);
    #2;
    ereset_a = 1'b0;
    #1;
    chk("async_clk2out", 32'(clk2out_a), 32'h0);
    chk("async_rw", 32'(rw_a), 32'h1);
    chk("async_ab", 32'(ab_a), 32'h0);
    chk("async_busy", 32'(busy_a), 32'h0);
    reset_a();
    seen16 = '0; exp16 = '0; viol = 0;
    for (int k = 0; k < 16; k++) begin
      seen16[k] = clk2out_a;
      exp16[k]  = ((k % 8) >= 4);
      if (!rw_a || busy_a) viol++;
      tick();
    end
    chk("post_rst_phase", 32'(seen16), 32'(exp16));
    chk("post_rst_empty", 32'(viol), 32'h0);

    // Idle after a read of 0x1234
    reset_a();
    push_a(1'b1, 16'h1234, 8'h00);
    wait_idle_a("idle_rd_done");
    chk("idle_rd_data", 32'(rsp_data_a), 32'h5C);
    consume_a();
    viol = 0;
    for (int k = 0; k < 24; k++) begin
      if (ab_a != 16'h1234 || !rw_a || rsp_valid_a || busy_a) viol++;
      tick();
    end
    chk("idle_hold", 32'(viol), 32'h0);
    chk("idle_ab", 32'(ab_a), 32'h1234);

    // 1/1 phases: alternate writes and reads of 0xFFFF
    ereset_b = 1'b1;
    seen12 = '0; exp12 = '0; ready_lo = 0;
    for (int k = 0; k < 12; k++) begin
      seen12[k]   = clk2out_b;
      exp12[k]    = k[0];
      cmd_valid_b = (k < 4);
      cmd_rw_b    = k[0];
      cmd_addr_b  = 16'hFFFF;
      cmd_wdata_b = (k == 0) ? 8'h5A : 8'hA5;
      if (k < 4 && !cmd_ready_b) ready_lo++;
      if (rsp_valid_b) rq.push_back(rsp_data_b);
      if (k == 3) begin
        chk("b_wr_rw", 32'(rw_b), 32'h0);
        chk("b_wr_db_o", 32'(db_o_b), 32'h5A);
      end
      if (k == 6) chk("b_rsp_timing", 32'(rsp_valid_b), 32'h1);
      tick();
    end
    cmd_valid_b = 1'b0;
    chk("b_ready", 32'(ready_lo), 32'h0);
    chk("b_clk2out_toggle", 32'(seen12), 32'(exp12));
    chk("b_rsp_count", 32'(rq.size()), 32'd2);
    if (rq.size() == 2) begin
      chk("b_rsp0", 32'(rq[0]), 32'h5A);
      chk("b_rsp1", 32'(rq[1]), 32'hA5);
    end
    chk("b_busy_done", 32'(busy_b), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
